hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
// - Producer-side companion to the EX-stage bypass logic. Tracks in-flight register writes from issue to
//   the cycle each result first reaches a bypass point. Stalls the ID stage whenever a source operand
//   cannot yet be bypassed.
// - Handles load-use hazards, multi-cycle MUL/DIV results, WAW ordering and the single MUL/DIV unit.
// - Sits between the ID stage and the IF/ID and ID/EX pipeline registers.
// PARAMETERS
// - NUM_REGS    32  architectural registers; r0 is hard-wired to zero.
// - MULDIV_LAT   4  cycles from MUL/DIV issue until the result can be bypassed (>=2).
// PORTS
// - clk             in   1  single rising-edge clock.
// - reset           in   1  synchronous, active-high reset.
// - ID_Valid        in   1  ID holds a real instruction (not a bubble).
// - ID_Flush        in   1  squash the ID instruction this cycle (branch taken). Blocks allocation and stall.
// - ID_Reg_Rs       in   5  source register 1.
// - ID_Reg_Rt       in   5  source register 2.
// - ID_Reg_Rd       in   5  destination register (post RegDst mux).
// - ID_Uses_Rs      in   1  instruction reads Rs.
// - ID_Uses_Rt      in   1  instruction reads Rt.
// - ID_RegWrite     in   1  instruction writes Rd.
// - ID_Class        in   2  00=ALU, 01=LOAD, 10=MULDIV, 11=reserved (treated as ALU).
// - Stall           out  1  hold PC and IF/ID; insert a bubble into ID/EX.
// - MulDiv_Busy     out  1  MUL/DIV unit occupied.
// BEHAVIOUR
// - State: wait_cnt[1..NUM_REGS-1], each CW=$clog2(MULDIV_LAT+1) bits; md_cnt, CW bits.
//   - wait_cnt = remaining cycles a dependent instruction in ID must wait. 0 means bypassable or committed.
// - Reset: all wait_cnt=0, md_cnt=0. Stall=0 and MulDiv_Busy=0 in the first cycle after reset.
//   - Reset mid-MUL/DIV discards all pending state.
// - Stall is combinational from current state plus ID inputs. It is asserted only when
//   ID_Valid & ~ID_Flush and at least one of the following holds:
//   (a) RAW: ID_Uses_Rs & Rs!=0 & wait_cnt[Rs]!=0, or the same condition on Rt.
//   (b) WAW: ID_RegWrite & Rd!=0 & wait_cnt[Rd]!=0.
//   (c) Structural: ID_Class==MULDIV & md_cnt>1.
// - Issue = ID_Valid & ~ID_Flush & ~Stall.
// - Per cycle, every nonzero wait_cnt decrements by 1. md_cnt decrements by 1 while nonzero.
// - On issue with ID_RegWrite & Rd!=0, wait_cnt[Rd] is loaded:
//   - ALU: 0. The result is bypassed from EX/MEM the next cycle, so no stall is needed.
//   - LOAD: 1. This gives exactly one bubble for an immediately dependent instruction.
//   - MULDIV: MULDIV_LAT-1.
//   - The load overrides the decrement for that entry. No conflict exists, because the WAW rule
//     guarantees the entry is 0.
// - On issue with ID_Class==MULDIV, md_cnt loads MULDIV_LAT-1, regardless of RegWrite.
//   - Back-to-back MUL/DIV issue is allowed in the cycle md_cnt==1 (pipelined handoff).
// - MulDiv_Busy = (md_cnt!=0).
// - Writes to r0 are never tracked. Reads of r0 never stall.
// - Rs==Rt==Rd all pending: one stall, no double counting.
// - Stall is monotone: once the hazard clears through countdown, Stall drops in that same cycle.
//   No extra bubble is added.
// - ID_Flush while a hazard is pending: Stall=0 and nothing is allocated. In-flight counters keep counting.
// STRUCTURE
// - Shared pipeline package holds: the class encodings (CLASS_ALU/LOAD/MULDIV), REG_ADDR_W=5,
//   and the MULDIV_LAT default.
// - One sub-module, sb_entry (a loadable down-counter with a nonzero flag), instantiated NUM_REGS-1
//   times via generate. The top level holds the hazard compare and md_cnt.
// TESTING
// - Reset: hold reset 2 cycles with ID_Valid=1 and sources pending.
//   -> Stall=0 and MulDiv_Busy=0 after release; all counters 0.
// - Load-use: LOAD r5, then ADD r6,r5,r1.
//   -> Stall=1 for exactly 1 cycle, then issue; ALU-ALU dependency r7=r6+r6 -> Stall=0.
// - MULDIV (LAT=4): MUL r8, then ADD r9,r8,r2 on the next cycle.
//   -> Stall for 3 cycles; MulDiv_Busy high for 3 cycles.
// - Structural/WAW: MUL r8, then MUL r10 next cycle -> stalls 2 cycles.
//   MUL r8 then LOAD r8 -> stalls until wait_cnt[r8]=0.
// - r0 and flush: LOAD r0, then ADD r1,r0,r0 -> Stall=0.
//   LOAD r5, then ADD r6,r5 with ID_Flush=1 -> Stall=0 and no allocation for r6.
// - Random: constrained-random stream checked against a cycle-accurate reference model.
//   -> Stall matches every cycle; no dependent instruction issues before its wait_cnt reaches 0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions: instruction class encodings, register address width
// and the default MUL/DIV bypass latency.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W         = 5;
  localparam int unsigned MULDIV_LAT_DEFAULT = 4;

  typedef enum logic [1:0] {
    CLASS_ALU    = 2'b00,
    CLASS_LOAD   = 2'b01,
    CLASS_MULDIV = 2'b10,
    CLASS_RSVD   = 2'b11
  } iclass_e;

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard slot: loadable saturating down-counter of cycles until the
// register's pending result can be bypassed.
module sb_entry #(
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          nonzero
);

  logic [CW-1:0] count;

  // A load only happens when the slot is already zero, so it simply wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: stalls on RAW/WAW against in-flight writes and on
// the single MUL/DIV unit, tracking each result until it reaches a bypass point.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ID_Valid,
  input  logic                  ID_Flush,
  input  logic [REG_ADDR_W-1:0] ID_Reg_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Reg_Rt,
  input  logic [REG_ADDR_W-1:0] ID_Reg_Rd,
  input  logic                  ID_Uses_Rs,
  input  logic                  ID_Uses_Rt,
  input  logic                  ID_RegWrite,
  input  logic [1:0]            ID_Class,
  output logic                  Stall,
  output logic                  MulDiv_Busy
);

  localparam int unsigned CW = $clog2(MULDIV_LAT + 1);

  logic [NUM_REGS-1:0] wait_nz;
  logic [CW-1:0]       md_cnt;
  logic [CW-1:0]       md_nxt;
  logic [CW-1:0]       alloc_val;
  logic                is_muldiv;
  logic                raw_haz;
  logic                waw_haz;
  logic                struct_haz;
  logic                issue;
  logic                alloc;

  assign wait_nz[0] = 1'b0;
  assign is_muldiv  = (ID_Class == CLASS_MULDIV);

  assign raw_haz = (ID_Uses_Rs && (ID_Reg_Rs != '0) && wait_nz[ID_Reg_Rs]) ||
                   (ID_Uses_Rt && (ID_Reg_Rt != '0) && wait_nz[ID_Reg_Rt]);
  assign waw_haz    = ID_RegWrite && (ID_Reg_Rd != '0) && wait_nz[ID_Reg_Rd];
  // md_cnt==1 still allows a pipelined hand-off to the next MUL/DIV.
  assign struct_haz = is_muldiv && (md_cnt > CW'(1));

  assign Stall = ID_Valid && !ID_Flush && (raw_haz || waw_haz || struct_haz);
  assign issue = ID_Valid && !ID_Flush && !Stall;
  assign alloc = issue && ID_RegWrite && (ID_Reg_Rd != '0);

  always_comb begin
    alloc_val = '0;
    case (ID_Class)
      CLASS_LOAD:   alloc_val = CW'(1);
      CLASS_MULDIV: alloc_val = CW'(MULDIV_LAT - 1);
      default:      alloc_val = '0;
    endcase
  end

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    sb_entry #(.CW(CW)) u_entry (
      .clk      (clk),
      .reset    (reset),
      .load     (alloc && (ID_Reg_Rd == REG_ADDR_W'(i))),
      .load_val (alloc_val),
      .nonzero  (wait_nz[i])
    );
  end

  always_comb begin
    md_nxt = md_cnt;
    if (issue && is_muldiv) begin
      md_nxt = CW'(MULDIV_LAT - 1);
    end else if (md_cnt != '0) begin
      md_nxt = md_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt      <= '0;
      MulDiv_Busy <= 1'b0;
    end else begin
      md_cnt      <= md_nxt;
      MulDiv_Busy <= (md_nxt != '0);
    end
  end

endmodule
